exception_vector_sequencer: RTL

- Multicycle sequencer between the main control unit and the memory address mux of the MIPS datapath.
- On an exception it overrides the mux selector to point memory at the exception vector byte: 253 for invalid opcode, 254 for overflow, 255 for divide-by-zero.
- It waits out the memory read latency, then loads PC with the zero-extended handler byte and EPC with the faulting instruction address.
- When idle it passes the control unit's selector through unchanged.

---
 rtl/exception_vector_sequencer_if.sv | 34 +++
 rtl/exception_vector_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/exception_vector_sequencer_if.sv
// Signal bundle between the control unit/memory side and the exception vector sequencer.
// The sequencer connects through the slave modport; the surrounding datapath uses master.
interface exception_vector_sequencer_if;
    logic [2:0]  ctrl_mem_sel;
    logic        ctrl_mem_wr;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_divzero;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic [2:0]  mem_sel_out;
    logic        mem_wr_out;
    logic        pc_wr;
    logic [31:0] pc_data;
    logic        epc_wr;
    logic [31:0] epc_data;
    logic [1:0]  exc_cause;
    logic        busy;
    logic        exc_done;

    modport slave (
        input  ctrl_mem_sel, ctrl_mem_wr, exc_opcode, exc_overflow, exc_divzero,
               pc_in, mem_data_in,
        output mem_sel_out, mem_wr_out, pc_wr, pc_data, epc_wr, epc_data,
               exc_cause, busy, exc_done
    );

    modport master (
        output ctrl_mem_sel, ctrl_mem_wr, exc_opcode, exc_overflow, exc_divzero,
               pc_in, mem_data_in,
        input  mem_sel_out, mem_wr_out, pc_wr, pc_data, epc_wr, epc_data,
               exc_cause, busy, exc_done
    );
endinterface

// File: rtl/exception_vector_sequencer.sv
// Exception sequencer: steers memory to the vector byte, loads PC/EPC after MEM_LATENCY+2 cycles.
// Holds busy for MEM_LATENCY+3 cycles; exceptions raised while busy are dropped, not queued.
module exception_vector_sequencer #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    exception_vector_sequencer_if.slave   bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] SEL_VEC_OPCODE   = 3'b000;
    localparam logic [2:0] SEL_PC           = 3'b001;
    localparam logic [2:0] SEL_VEC_OVERFLOW = 3'b011;
    localparam logic [2:0] SEL_VEC_DIVZERO  = 3'b101;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cause;
    logic [31:0]      epc;
    logic [2:0]       vec_sel;
    logic             any_exc;
    logic             unused_mem_low;

    assign any_exc        = bus.exc_opcode | bus.exc_overflow | bus.exc_divzero;
    // Only the top byte of the memory word carries the handler address.
    assign unused_mem_low = ^bus.mem_data_in[23:0];

    always_comb begin
        vec_sel = SEL_PC;
        case (cause)
            2'b01:   vec_sel = SEL_VEC_OPCODE;
            2'b10:   vec_sel = SEL_VEC_OVERFLOW;
            2'b11:   vec_sel = SEL_VEC_DIVZERO;
            default: vec_sel = SEL_PC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            cause <= 2'b00;
            epc   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_exc) begin
                        if (bus.exc_opcode)        cause <= 2'b01;
                        else if (bus.exc_overflow) cause <= 2'b10;
                        else                       cause <= 2'b11;
                        epc   <= bus.pc_in - 32'd4;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    cnt   <= CNT_W'(MEM_LATENCY - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_LOAD;
                    else           cnt   <= cnt - 1'b1;
                end
                S_LOAD:  state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_sel_out = bus.ctrl_mem_sel;
        bus.mem_wr_out  = 1'b0;
        bus.pc_wr       = 1'b0;
        bus.pc_data     = 32'd0;
        bus.epc_wr      = 1'b0;
        bus.busy        = 1'b1;
        bus.exc_done    = 1'b0;
        case (state)
            S_IDLE: begin
                bus.mem_wr_out = bus.ctrl_mem_wr;
                bus.busy       = 1'b0;
            end
            S_ADDR, S_WAIT: bus.mem_sel_out = vec_sel;
            S_LOAD: begin
                bus.mem_sel_out = vec_sel;
                bus.pc_wr       = 1'b1;
                bus.pc_data     = {24'd0, bus.mem_data_in[31:24]};
                bus.epc_wr      = 1'b1;
            end
            S_DONE:  bus.exc_done = 1'b1;
            default: bus.busy     = 1'b1;
        endcase
    end

    assign bus.exc_cause = cause;
    assign bus.epc_data  = epc;

endmodule
